l2_arbiter: RTL and testbench

//  Shares the single unified L2 cache port (256-bit line interface) between the

---
 rtl/l2_arbiter.sv | 101 ++++++++++
 tb/tb_l2_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-requester arbiter in front of the unified L2 port: one L2 transaction per grant,
// round-robin on simultaneous requests, response steered back to the granted L1.
module l2_arbiter #(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       l2_address,
  input  logic [s_line-1:0] l2_rdata,
  output logic [s_line-1:0] l2_wdata,
  output logic              l2_read,
  output logic              l2_write,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   i_req, d_req;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    l2_address   = 32'h0;
    l2_wdata     = '0;
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time goes first.
        if (i_req && d_req) begin
          if (last_grant_q) begin
            state_d      = SERVE_I;
            last_grant_d = 1'b0;
          end else begin
            state_d      = SERVE_D;
            last_grant_d = 1'b1;
          end
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = 1'b0;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = 1'b1;
        end
      end
      SERVE_I: begin
        l2_address = i_addr;
        l2_read    = i_read;
        if (l2_resp) begin
          i_resp  = 1'b1;
          state_d = DONE;
        end
      end
      SERVE_D: begin
        l2_address = d_addr;
        l2_read    = d_read;
        l2_write   = d_write;
        l2_wdata   = d_wdata;
        if (l2_resp) begin
          d_resp  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Gap cycle so the finished requester can drop its request before re-arbitration.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized scoreboard bench for l2_arbiter: the driver predicts grant order from the
// arbitration rules and queues expected transactions; a monitor checks what the DUT presents.
module tb_l2_arbiter;
  localparam int SL = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   i_addr = '0, d_addr = '0;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [SL-1:0] d_wdata = '0;
  logic [SL-1:0] i_rdata, d_rdata, l2_wdata;
  logic          i_resp, d_resp;
  logic [31:0]   l2_address;
  logic [SL-1:0] l2_rdata = '0;
  logic          l2_read, l2_write;
  logic          rsp_auto = 1'b0, force_resp = 1'b0;
  wire           l2_resp = rsp_auto | force_resp;

  l2_arbiter #(.s_line(SL)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_rdata(l2_rdata), .l2_wdata(l2_wdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            side;   // 0 = I, 1 = D
    logic [31:0]   addr;
    bit            wr;
    logic [SL-1:0] wdata;
    int            ready;  // earliest cycle the strobe may appear
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_last = 1'b0;
  bit   rsp_en = 1'b1;
  int   force_lat = -1;

  function automatic void check(string name, logic [SL-1:0] act, logic [SL-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [SL-1:0] rand_line();
    logic [SL-1:0] r;
    for (int k = 0; k < SL / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // L2 model: answers each strobe after 0..3 wait cycles with fresh random data.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_en && (l2_read || l2_write)) begin
        int lat;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        repeat (lat) @(posedge clk);
        @(posedge clk); #1;
        if (!rst && rsp_en) begin
          l2_rdata = rand_line();
          rsp_auto = 1'b1;
          @(posedge clk); #1;
          rsp_auto = 1'b0;
        end
      end
    end
  end

  // Monitor
  bit   in_txn = 1'b0;
  bit   prev_resp = 1'b0;
  int   last_resp = -100;
  exp_t cur;
  logic strobe;

  always @(negedge clk) begin
    if (rst) begin
      in_txn    = 1'b0;
      prev_resp = 1'b0;
      last_resp = -100;
    end else begin
      strobe = l2_read | l2_write;
      if (prev_resp) check("done_strobes_low", SL'(strobe), SL'(0));
      if (strobe && !in_txn) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant actual=addr %h required=no grant", l2_address);
        end else begin
          cur    = expq.pop_front();
          in_txn = 1'b1;
          check("grant_cycle", SL'(cyc), SL'((cur.ready > last_resp + 3) ? cur.ready : last_resp + 3));
          check("grant_addr", SL'(l2_address), SL'(cur.addr));
          check("grant_read", SL'(l2_read), SL'(!cur.wr));
          check("grant_write", SL'(l2_write), SL'(cur.wr));
          check("grant_wdata", l2_wdata, cur.wdata);
        end
      end
      if (l2_resp) begin
        check("i_resp", SL'(i_resp), SL'(in_txn && !cur.side));
        check("d_resp", SL'(d_resp), SL'(in_txn && cur.side));
        if (in_txn) begin
          if (cur.side) check("d_rdata", d_rdata, l2_rdata);
          else          check("i_rdata", i_rdata, l2_rdata);
          last_resp = cyc;
        end
        prev_resp = in_txn;
        in_txn    = 1'b0;
      end else begin
        check("no_resp", SL'({i_resp, d_resp}), SL'(0));
        prev_resp = 1'b0;
      end
    end
  end

  task automatic push(input exp_t e);
    model_last = e.side;
    expq.push_back(e);
  endtask

  task automatic mk_i(output exp_t e);
    i_addr  = $urandom & 32'hFFFF_FFE0;
    i_read  = 1'b1;
    e.side  = 1'b0;
    e.addr  = i_addr;
    e.wr    = 1'b0;
    e.wdata = '0;
    e.ready = cyc + 1;
  endtask

  task automatic mk_d(input bit wr, output exp_t e);
    d_addr  = $urandom & 32'hFFFF_FFE0;
    d_wdata = rand_line();
    d_read  = !wr;
    d_write = wr;
    e.side  = 1'b1;
    e.addr  = d_addr;
    e.wr    = wr;
    e.wdata = d_wdata;
    e.ready = cyc + 1;
  endtask

  // Raise I at offset ti and D at offset td (-1 = unused); both at 0 is a tie.
  task automatic run(input int ti, input int td, input bit dw);
    exp_t ei, ed;
    bit   pi = 1'b0, pd = 1'b0;
    logic gi, gd;
    int   t = 0, budget = 400;
    if (ti == 0 && td == 0) begin
      mk_i(ei);
      mk_d(dw, ed);
      if (model_last) begin push(ei); push(ed); end
      else            begin push(ed); push(ei); end
      pi = 1'b1;
      pd = 1'b1;
    end else begin
      if (ti == 0) begin mk_i(ei); push(ei); pi = 1'b1; end
      if (td == 0) begin mk_d(dw, ed); push(ed); pd = 1'b1; end
    end
    while ((pi || pd || t < ti || t < td) && budget > 0) begin
      @(negedge clk);
      gi = i_resp;
      gd = d_resp;
      @(posedge clk); #1;
      t++;
      budget--;
      if (gi && pi) begin i_read = 1'b0; pi = 1'b0; end
      if (gd && pd) begin d_read = 1'b0; d_write = 1'b0; pd = 1'b0; end
      if (t == ti) begin mk_i(ei); push(ei); pi = 1'b1; end
      if (t == td) begin mk_d(dw, ed); push(ed); pd = 1'b1; end
    end
    if (pi || pd) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=pending i%0d d%0d required=all responded", pi, pd);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // D reads re-raised in the DONE cycle, so every grant follows the previous one directly.
  task automatic b2b(input int n);
    exp_t e;
    logic gd;
    int   budget;
    mk_d(1'b0, e);
    push(e);
    for (int k = 0; k < n; k++) begin
      budget = 100;
      gd = 1'b0;
      while (!gd && budget > 0) begin
        @(negedge clk);
        gd = d_resp;
        @(posedge clk); #1;
        budget--;
      end
      if (!gd) begin
        checks++;
        errors++;
        $display("FAIL b2b_timeout actual=no d_resp required=d_resp");
      end
      if (k < n - 1) begin mk_d(1'b0, e); push(e); end
      else d_read = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_serve();
    exp_t e;
    logic gi;
    int   budget = 100;
    rsp_en = 1'b0;
    mk_d(1'b1, e);
    push(e);
    @(posedge clk); #1;
    i_addr = 32'h0000_3000;
    i_read = 1'b1;
    @(posedge clk); #2;
    force_resp = 1'b1;
    #1;
    check("pre_rst_d_resp", SL'(d_resp), SL'(1));
    rst = 1'b1;
    #1;
    check("rst_l2_read", SL'(l2_read), SL'(0));
    check("rst_l2_write", SL'(l2_write), SL'(0));
    check("rst_d_resp", SL'(d_resp), SL'(0));
    check("rst_i_resp", SL'(i_resp), SL'(0));
    force_resp = 1'b0;
    d_write = 1'b0;
    expq.delete();
    model_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_en = 1'b1;
    e.side = 1'b0; e.addr = i_addr; e.wr = 1'b0; e.wdata = '0; e.ready = cyc + 1;
    push(e);
    gi = 1'b0;
    while (!gi && budget > 0) begin
      @(negedge clk);
      gi = i_resp;
      @(posedge clk); #1;
      budget--;
    end
    check("post_rst_i_served", SL'(gi), SL'(1));
    i_read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode, dly;
    repeat (3) @(negedge clk);
    check("reset_l2_read", SL'(l2_read), SL'(0));
    check("reset_l2_write", SL'(l2_write), SL'(0));
    check("reset_resps", SL'({i_resp, d_resp}), SL'(0));
    check("reset_l2_address", SL'(l2_address), SL'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 0, 1'b0);                  // first tie after reset: D then I
    run(0, 0, 1'b0);                  // repeated tie alternates the same way
    force_lat = 2;
    run(0, -1, 1'b0);                 // single I read, response 3 cycles after grant
    force_lat = -1;
    run(-1, 0, 1'b1);                 // single D writeback
    b2b(4);
    force_resp = 1'b1;                // l2_resp while idle must be ignored
    @(posedge clk); #1;
    force_resp = 1'b0;
    @(posedge clk); #1;
    run(0, -1, 1'b0);
    reset_mid_serve();
    run(0, 0, 1'b1);

    for (int r = 0; r < 60; r++) begin
      mode = $urandom_range(0, 3);
      dly  = $urandom_range(1, 5);
      case (mode)
        0: run(0, -1, 1'b0);
        1: run(-1, 0, 1'($urandom_range(0, 1)));
        2: run(0, 0, 1'($urandom_range(0, 1)));
        default: begin
          if ($urandom_range(0, 1) == 1) run(0, dly, 1'($urandom_range(0, 1)));
          else                           run(dly, 0, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", SL'(expq.size()), SL'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
